hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clk in 1, rising-edge clock; Rst in 1, asynchronous active-low reset.
REQ-002 The ID-side inputs SHALL be:
- ID_Regrs in 5, source register A of the decode-stage instruction.
- ID_Regrt in 5, source register B of the decode-stage instruction.
- ID_UsesRs in 1, the decode instruction reads rs.
- ID_UsesRt in 1, the decode instruction reads rt.
REQ-003 The EX-side inputs SHALL be taken from the ID/EX pipeline-register outputs:
- EX_RegDst in 1.
- EX_RegWrite in 1.
- EX_MemToReg in 1, the EX instruction is a load.
- EX_Regrt in 5.
- EX_Regrd in 5.
REQ-004 Branch_Taken in 1 SHALL mean that the branch resolved in EX redirects the PC this cycle.
REQ-005 The outputs SHALL be:
- Stall_IF out 1, hold the PC.
- Stall_ID out 1, hold the IF/ID register.
- Flush_ID out 1, zero the IF/ID instruction.
- Flush_EX out 1, load a bubble (all control zero) into ID/EX.
- FwdA out 2, ID-stage operand-A source select.
- FwdB out 2, ID-stage operand-B source select.
- StallCnt out 16, performance counter of stall cycles.
- FlushCnt out 16, performance counter of flush events.

Function
REQ-006 EX destination SHALL be EX_Regrd when EX_RegDst=1, else EX_Regrt.
REQ-007 The scoreboard SHALL hold MEM-stage {M_Dst[4:0], M_Wr, M_Ld} and WB-stage {W_Dst[4:0], W_Wr}, updated each rising Clk as follows:
- WB takes the MEM values.
- MEM takes the EX destination, EX_RegWrite and EX_MemToReg.
REQ-008 When Flush_EX=1, the scoreboard SHALL still shift, because EX already holds the bubble written in the previous cycle.
REQ-009 A stage SHALL match a source only if all of these hold:
- its write flag is 1;
- its destination is nonzero;
- its destination equals the source;
- the corresponding ID_Uses bit is 1.
REQ-010 Destination register 0 SHALL never cause forwarding or a stall.
REQ-011 Forward encoding SHALL be 00 register file, 01 EX ALU result, 10 MEM ALU result, 11 WB result.
REQ-012 Forward priority SHALL be EX over MEM over WB, with the rest of this requirement applying per operand:
- EX match with EX_MemToReg=1 is not forwardable;
- MEM match with M_Ld=1 is not forwardable;
- in those two cases the select is 00 and a load-use condition is raised.
REQ-013 The FSM SHALL have states RUN, LU2 and LU1.
REQ-014 In RUN, the FSM SHALL transition as follows:
- load-use with EX load: assert stall, next state LU1;
- load-use with MEM load only: assert stall, stay in RUN;
- otherwise: no stall.
REQ-015 In LU1, the FSM SHALL assert stall unconditionally and return to RUN; LU2 is reserved, decodes as RUN, and SHALL never be entered.
REQ-016 While stall is asserted, the outputs SHALL be Stall_IF=1, Stall_ID=1, Flush_EX=1, Flush_ID=0.
REQ-017 Branch_Taken=1 SHALL override stall:
- Flush_ID=1 and Flush_EX=1;
- Stall_IF=0 and Stall_ID=0;
- next state RUN, cancelling any pending LU1.
REQ-018 Stall and flush outputs SHALL be combinational from the current state, scoreboard, EX inputs and ID inputs, with zero-cycle latency; FSM state, scoreboard and counters SHALL be registered.
REQ-019 StallCnt SHALL increment by 1 on each Clk edge where Stall_IF=1, saturating at 16'hFFFF.
REQ-020 FlushCnt SHALL increment by 1 on each Clk edge where Branch_Taken=1, saturating at 16'hFFFF.
REQ-021 When Branch_Taken and a load-use condition occur in the same cycle, FlushCnt SHALL increment and StallCnt SHALL not.

Reset
REQ-022 Rst=0 SHALL immediately, without waiting for Clk:
- put the FSM in RUN;
- clear M_Dst, M_Wr, M_Ld, W_Dst and W_Wr to 0;
- clear StallCnt and FlushCnt to 0.
REQ-023 During reset, the outputs SHALL therefore be Stall_IF=Stall_ID=Flush_ID=Flush_EX=0 and FwdA=FwdB=00, provided Branch_Taken=0 and the ID_Uses inputs give no match.
REQ-024 When Rst is deasserted, the block SHALL resume on the next rising Clk, and a reset asserted mid-stall SHALL abandon the stall.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Load-use from EX: EX_MemToReg=1, EX_RegWrite=1, EX_RegDst=0, EX_Regrt=5; ID_Regrs=5, ID_UsesRs=1 -> Stall_IF and Flush_EX are 1 for exactly 2 cycles, then FwdA=11 with no stall; StallCnt=2.
- ALU hazard: EX_RegWrite=1, EX_MemToReg=0, EX_RegDst=1, EX_Regrd=7; ID_Regrs=ID_Regrt=7, both uses=1 -> FwdA=FwdB=01 and no stall.
- Register 0: an EX write to destination 0 with ID_Regrs=0 -> FwdA=00 and no stall.
- Double writer: EX and MEM both write 9 and ID_Regrt=9 -> FwdB=01; one cycle later, with EX not writing 9 -> FwdB=10.
- Branch in LU1: Branch_Taken=1 while in LU1 -> Flush_ID=1, Flush_EX=1, Stall_IF=0, next state RUN, FlushCnt incremented, StallCnt unchanged.
- Async reset mid-stall: Rst=0 between clock edges during LU1 -> stall outputs 0 before the next edge; StallCnt=0 and FlushCnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard detection, forwarding select, and stall/flush control with perf counters
// Ports:
//   Clk, Rst                 rising-edge clock, asynchronous active-low reset
//   ID_Regrs/Regrt/UsesRs/Rt decode-stage source registers and their use flags
//   EX_RegDst/RegWrite/MemToReg/Regrt/Regrd  ID/EX pipeline-register control and register fields
//   Branch_Taken             branch resolved in EX redirects the PC this cycle
//   Stall_IF/Stall_ID        hold PC / hold IF/ID
//   Flush_ID/Flush_EX        zero IF/ID instruction / load a bubble into ID/EX
//   FwdA/FwdB                operand source: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 WB
//   StallCnt/FlushCnt        saturating stall-cycle and flush-event counters
module hazard_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Regrs,
  input  logic [4:0]  ID_Regrt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        EX_RegDst,
  input  logic        EX_RegWrite,
  input  logic        EX_MemToReg,
  input  logic [4:0]  EX_Regrt,
  input  logic [4:0]  EX_Regrd,
  input  logic        Branch_Taken,
  output logic        Stall_IF,
  output logic        Stall_ID,
  output logic        Flush_ID,
  output logic        Flush_EX,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);
  // LU2 is a reserved encoding that is never entered and behaves as RUN
  typedef enum logic [1:0] {RUN = 2'd0, LU2 = 2'd1, LU1 = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [4:0]  m_dst_q, w_dst_q;
  logic        m_wr_q, m_ld_q, w_wr_q;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [4:0]  ex_dst;
  logic        ex_a, ex_b, m_a, m_b, w_a, w_b;
  logic        lu_ex, lu_mem, stall;
  assign ex_dst = EX_RegDst ? EX_Regrd : EX_Regrt;
  // register 0 is hardwired, so a zero destination never matches
  assign ex_a = ID_UsesRs && EX_RegWrite && ex_dst != 5'd0 && ex_dst == ID_Regrs;
  assign ex_b = ID_UsesRt && EX_RegWrite && ex_dst != 5'd0 && ex_dst == ID_Regrt;
  assign m_a  = ID_UsesRs && m_wr_q && m_dst_q != 5'd0 && m_dst_q == ID_Regrs;
  assign m_b  = ID_UsesRt && m_wr_q && m_dst_q != 5'd0 && m_dst_q == ID_Regrt;
  assign w_a  = ID_UsesRs && w_wr_q && w_dst_q != 5'd0 && w_dst_q == ID_Regrs;
  assign w_b  = ID_UsesRt && w_wr_q && w_dst_q != 5'd0 && w_dst_q == ID_Regrt;
  // a load result is not yet available in EX or MEM: select regfile and stall instead
  assign FwdA = ex_a ? (EX_MemToReg ? 2'b00 : 2'b01)
              : m_a ? (m_ld_q ? 2'b00 : 2'b10)
              : w_a ? 2'b11 : 2'b00;
  assign FwdB = ex_b ? (EX_MemToReg ? 2'b00 : 2'b01)
              : m_b ? (m_ld_q ? 2'b00 : 2'b10)
              : w_b ? 2'b11 : 2'b00;
  assign lu_ex  = (ex_a || ex_b) && EX_MemToReg;
  // MEM load only counts when the younger EX writer does not shadow it
  assign lu_mem = ((!ex_a && m_a) || (!ex_b && m_b)) && m_ld_q;
  always_comb begin
    state_d = RUN;
    stall   = 1'b0;
    if (state_q == LU1) begin
      stall = 1'b1;
    end else if (lu_ex) begin
      stall   = 1'b1;
      state_d = LU1;
    end else if (lu_mem) begin
      stall = 1'b1;
    end
    if (Branch_Taken) state_d = RUN;
  end
  assign Stall_IF = stall && !Branch_Taken;
  assign Stall_ID = stall && !Branch_Taken;
  assign Flush_ID = Branch_Taken;
  assign Flush_EX = stall || Branch_Taken;
  assign stall_cnt_d = (Stall_IF && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  assign flush_cnt_d = (Branch_Taken && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  // scoreboard shifts every cycle; on a flush EX already carries the bubble
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= RUN;
      m_dst_q     <= 5'd0;
      m_wr_q      <= 1'b0;
      m_ld_q      <= 1'b0;
      w_dst_q     <= 5'd0;
      w_wr_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      w_dst_q     <= m_dst_q;
      w_wr_q      <= m_wr_q;
      m_dst_q     <= ex_dst;
      m_wr_q      <= EX_RegWrite;
      m_ld_q      <= EX_MemToReg;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for hazard_ctrl
module tb_hazard_ctrl;
  logic        Clk, Rst;
  logic [4:0]  ID_Regrs, ID_Regrt, EX_Regrt, EX_Regrd;
  logic        ID_UsesRs, ID_UsesRt, EX_RegDst, EX_RegWrite, EX_MemToReg, Branch_Taken;
  logic        Stall_IF, Stall_ID, Flush_ID, Flush_EX;
  logic [1:0]  FwdA, FwdB;
  logic [15:0] StallCnt, FlushCnt;
  int n_vec = 0;
  int n_err = 0;
  hazard_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .ID_Regrs(ID_Regrs), .ID_Regrt(ID_Regrt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_RegDst(EX_RegDst), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_Regrt(EX_Regrt), .EX_Regrd(EX_Regrd), .Branch_Taken(Branch_Taken),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX),
    .FwdA(FwdA), .FwdB(FwdB), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // {Stall_IF, Stall_ID, Flush_ID, Flush_EX}: stall = d, branch flush = 3
  function automatic logic [15:0] ctl();
    return {12'd0, Stall_IF, Stall_ID, Flush_ID, Flush_EX};
  endfunction
  function automatic logic [15:0] fa();
    return {14'd0, FwdA};
  endfunction
  function automatic logic [15:0] fb();
    return {14'd0, FwdB};
  endfunction
  task automatic set_ex(input logic rw, input logic ml, input logic dst, input logic [4:0] rt, input logic [4:0] rd);
    EX_RegWrite = rw;
    EX_MemToReg = ml;
    EX_RegDst   = dst;
    EX_Regrt    = rt;
    EX_Regrd    = rd;
  endtask
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt);
    ID_Regrs  = rs;
    ID_Regrt  = rt;
    ID_UsesRs = urs;
    ID_UsesRt = urt;
  endtask
  task automatic step();
    @(negedge Clk);
  endtask
  initial begin
    Rst = 1'b0;
    Branch_Taken = 1'b0;
    set_ex(0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0);
    step();
    step();
    #1;
    chk("rst_ctl", ctl(), 16'h0);
    chk("rst_fwda", fa(), 16'd0);
    chk("rst_fwdb", fb(), 16'd0);
    chk("rst_stallcnt", StallCnt, 16'd0);
    chk("rst_flushcnt", FlushCnt, 16'd0);
    Rst = 1'b1;
    // load-use from EX: two stall cycles, then WB forward
    step(); set_ex(1, 1, 0, 5, 0); set_id(5, 0, 1, 0); #1;
    chk("luex_c0_ctl", ctl(), 16'hd);
    chk("luex_c0_fwda", fa(), 16'd0);
    step(); set_ex(0, 0, 0, 0, 0); #1;
    chk("luex_c1_ctl", ctl(), 16'hd);
    step(); #1;
    chk("luex_c2_ctl", ctl(), 16'h0);
    chk("luex_c2_fwda", fa(), 16'd3);
    chk("luex_stallcnt", StallCnt, 16'd2);
    chk("luex_flushcnt", FlushCnt, 16'd0);
    // ALU hazard through rd
    step(); set_ex(1, 0, 1, 3, 7); set_id(7, 7, 1, 1); #1;
    chk("alu_fwda", fa(), 16'd1);
    chk("alu_fwdb", fb(), 16'd1);
    chk("alu_ctl", ctl(), 16'h0);
    set_id(7, 7, 1, 0); #1;
    chk("alu_nouse_fwdb", fb(), 16'd0);
    // register 0 never forwards or stalls
    step(); set_ex(1, 0, 1, 3, 0); set_id(0, 0, 1, 0); #1;
    chk("r0_fwda", fa(), 16'd0);
    chk("r0_ctl", ctl(), 16'h0);
    set_ex(1, 1, 1, 3, 0); #1;
    chk("r0_load_ctl", ctl(), 16'h0);
    // double writer: EX beats MEM, then MEM, then WB
    step(); set_ex(1, 0, 0, 9, 0); set_id(0, 9, 0, 1); #1;
    chk("dbl_ex_fwdb", fb(), 16'd1);
    step(); #1;
    chk("dbl_both_fwdb", fb(), 16'd1);
    step(); set_ex(1, 0, 0, 4, 0); #1;
    chk("dbl_mem_fwdb", fb(), 16'd2);
    step(); set_ex(0, 0, 0, 0, 0); #1;
    chk("dbl_wb_fwdb", fb(), 16'd3);
    // load-use from MEM only: single stall cycle, state stays RUN
    step(); set_ex(1, 1, 0, 12, 0); set_id(0, 12, 0, 0); #1;
    chk("lumem_c0_ctl", ctl(), 16'h0);
    step(); set_ex(0, 0, 0, 0, 0); set_id(0, 12, 0, 1); #1;
    chk("lumem_c1_ctl", ctl(), 16'hd);
    chk("lumem_c1_fwdb", fb(), 16'd0);
    step(); #1;
    chk("lumem_c2_ctl", ctl(), 16'h0);
    chk("lumem_c2_fwdb", fb(), 16'd3);
    chk("lumem_stallcnt", StallCnt, 16'd3);
    // branch while in LU1
    step(); set_ex(1, 1, 0, 5, 0); set_id(5, 0, 1, 0); #1;
    chk("brlu1_c0_ctl", ctl(), 16'hd);
    step(); set_ex(0, 0, 0, 0, 0); Branch_Taken = 1'b1; #1;
    chk("brlu1_c1_ctl", ctl(), 16'h3);
    step(); Branch_Taken = 1'b0; #1;
    chk("brlu1_c2_ctl", ctl(), 16'h0);
    chk("brlu1_c2_fwda", fa(), 16'd3);
    chk("brlu1_stallcnt", StallCnt, 16'd4);
    chk("brlu1_flushcnt", FlushCnt, 16'd1);
    // branch and EX load-use in the same RUN cycle
    step(); set_ex(1, 1, 0, 6, 0); set_id(6, 0, 1, 0); Branch_Taken = 1'b1; #1;
    chk("brlu_ctl", ctl(), 16'h3);
    step(); set_ex(0, 0, 0, 0, 0); set_id(0, 0, 0, 0); Branch_Taken = 1'b0; #1;
    chk("brlu_next_ctl", ctl(), 16'h0);
    chk("brlu_stallcnt", StallCnt, 16'd4);
    chk("brlu_flushcnt", FlushCnt, 16'd2);
    // asynchronous reset between edges while in LU1
    step(); set_ex(1, 1, 0, 8, 0); set_id(8, 0, 1, 0); #1;
    chk("arst_c0_ctl", ctl(), 16'hd);
    step(); set_ex(0, 0, 0, 0, 0); set_id(0, 0, 0, 0); #1;
    chk("arst_lu1_ctl", ctl(), 16'hd);
    chk("arst_pre_stallcnt", StallCnt, 16'd5);
    Rst = 1'b0; #1;
    chk("arst_ctl", ctl(), 16'h0);
    chk("arst_stallcnt", StallCnt, 16'd0);
    chk("arst_flushcnt", FlushCnt, 16'd0);
    step(); Rst = 1'b1; #1;
    chk("arst_rel_ctl", ctl(), 16'h0);
    step(); #1;
    chk("arst_after_ctl", ctl(), 16'h0);
    chk("arst_after_stallcnt", StallCnt, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
